// File: rtl/hazard_issue_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_issue_ctrl
//
// Decode-to-execute issue stage of the 5-stage MIPS pipeline. Detects the
// hazards that forwarding cannot cover, stalls PC/FD, inserts bubbles and
// owns the DE pipeline register.
//
// Hazards detected:
//   - load-use                : load in DE feeding the decode instruction
//   - branch/jr operand (DE)  : any register producer in DE feeding a branch/jr
//   - branch/jr operand (EM)  : load in EM feeding a branch/jr
//   - mult/div busy           : mult/div start or hi/lo read while unit is busy
//
// Parameters:
//   MD_LATENCY   execute cycles of the iterative mult/div unit (2..15)
//
// Optional build macro:
//   HAZ_PERF_EN  adds Stall_Cnt, a wrapping count of stalled clock edges
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   FD_*                    fields of the instruction currently in decode
//   EM_*                    destination info of the instruction in EM
//   FD_Flush                taken branch/jump squashes the decode instruction
//   FD_Stall                hold PC and FD register (combinational)
//   DE_*                    registered issue fields (zero for a bubble)
//   MD_Busy                 mult/div unit occupied
//   Stall_Cnt               stall edge counter (HAZ_PERF_EN only)
// ---------------------------------------------------------------------------
module hazard_issue_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] FD_OpCode,
    input  logic [5:0] FD_Funct,
    input  logic [4:0] FD_Rs,
    input  logic [4:0] FD_Rt,
    input  logic [4:0] FD_RegWrAddr,
    input  logic       FD_RegWrite,
    input  logic       FD_MemRead,
    input  logic       FD_UsesRt,
    input  logic [4:0] EM_RegWrAddr,
    input  logic       EM_RegWrite,
    input  logic       EM_MemRead,
    input  logic       FD_Flush,
    output logic       FD_Stall,
    output logic [4:0] DE_Rs,
    output logic [4:0] DE_Rt,
    output logic [4:0] DE_RegWrAddr,
    output logic       DE_RegWrite,
    output logic       DE_MemRead,
    output logic       MD_Busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MD_LO   = 6'h18;
    localparam logic [5:0] FN_MD_HI   = 6'h1B;
    localparam logic [3:0] MD_LOAD    = 4'(MD_LATENCY);

    // Decode classes
    logic is_branch;
    logic is_jr;
    logic is_md_start;
    logic is_md_read;

    // Hazard terms
    logic lu_hazard;
    logic br_de_hazard;
    logic br_em_hazard;
    logic md_hazard;
    logic issue;

    logic [3:0] md_cnt;

    // A source only depends on a destination that is a real register;
    // writes to $0 never create a hazard.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != '0) && (src == dst);
    endfunction

    always_comb begin
        is_branch   = 1'b0;
        is_jr       = 1'b0;
        is_md_start = 1'b0;
        is_md_read  = 1'b0;
        if ((FD_OpCode == OP_BEQ) || (FD_OpCode == OP_BNE)) begin
            is_branch = 1'b1;
        end
        if (FD_OpCode == OP_SPECIAL) begin
            is_jr       = (FD_Funct == FN_JR) || (FD_Funct == FN_JALR);
            is_md_start = (FD_Funct >= FN_MD_LO) && (FD_Funct <= FN_MD_HI);
            is_md_read  = (FD_Funct == FN_MFHI) || (FD_Funct == FN_MFLO);
        end
    end

    always_comb begin
        lu_hazard    = 1'b0;
        br_de_hazard = 1'b0;
        br_em_hazard = 1'b0;
        md_hazard    = 1'b0;

        if (DE_MemRead && DE_RegWrite) begin
            lu_hazard = reg_hit(FD_Rs, DE_RegWrAddr) ||
                        (FD_UsesRt && reg_hit(FD_Rt, DE_RegWrAddr));
        end

        // Branch/jr resolve in decode, so even an ALU result in DE is too
        // late, and a load in EM is still one cycle short.
        if ((is_branch || is_jr) && DE_RegWrite) begin
            br_de_hazard = reg_hit(FD_Rs, DE_RegWrAddr) ||
                           (is_branch && reg_hit(FD_Rt, DE_RegWrAddr));
        end
        if ((is_branch || is_jr) && EM_MemRead && EM_RegWrite) begin
            br_em_hazard = reg_hit(FD_Rs, EM_RegWrAddr) ||
                           (is_branch && reg_hit(FD_Rt, EM_RegWrAddr));
        end

        md_hazard = (is_md_start || is_md_read) && MD_Busy;

        // A squashed instruction never needs to wait.
        FD_Stall = (lu_hazard || br_de_hazard || br_em_hazard || md_hazard) && !FD_Flush;
    end

    assign issue = !FD_Stall && !FD_Flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            DE_Rs        <= '0;
            DE_Rt        <= '0;
            DE_RegWrAddr <= '0;
            DE_RegWrite  <= 1'b0;
            DE_MemRead   <= 1'b0;
        end else if (issue) begin
            DE_Rs        <= FD_Rs;
            DE_Rt        <= FD_Rt;
            DE_RegWrAddr <= FD_RegWrAddr;
            DE_RegWrite  <= FD_RegWrite;
            DE_MemRead   <= FD_MemRead;
        end else begin
            DE_Rs        <= '0;
            DE_Rt        <= '0;
            DE_RegWrAddr <= '0;
            DE_RegWrite  <= 1'b0;
            DE_MemRead   <= 1'b0;
        end
    end

    // A start can only issue once the counter has drained (otherwise it
    // stalls), so the reload never collides with a pending decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (issue && is_md_start) begin
            md_cnt <= MD_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign MD_Busy = (md_cnt != '0);

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Stall_Cnt <= '0;
        end else if (FD_Stall) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_issue_ctrl
//
// Scoreboard bench for hazard_issue_ctrl. A driver issues directed and random
// instruction streams; a pipeline-level reference model derives the expected
// stall and issued DE contents and queues them; a monitor on the falling edge
// pops and compares. Define HAZ_PERF_EN to also check Stall_Cnt.
// ---------------------------------------------------------------------------
module tb_hazard_issue_ctrl;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [5:0] FD_OpCode = '0;
    logic [5:0] FD_Funct = '0;
    logic [4:0] FD_Rs = '0;
    logic [4:0] FD_Rt = '0;
    logic [4:0] FD_RegWrAddr = '0;
    logic       FD_RegWrite = 1'b0;
    logic       FD_MemRead = 1'b0;
    logic       FD_UsesRt = 1'b0;
    logic [4:0] EM_RegWrAddr = '0;
    logic       EM_RegWrite = 1'b0;
    logic       EM_MemRead = 1'b0;
    logic       FD_Flush = 1'b0;
    logic       FD_Stall;
    logic [4:0] DE_Rs;
    logic [4:0] DE_Rt;
    logic [4:0] DE_RegWrAddr;
    logic       DE_RegWrite;
    logic       DE_MemRead;
    logic       MD_Busy;
    logic [31:0] Stall_Cnt;

    always #5 clk = ~clk;

    hazard_issue_ctrl #(.MD_LATENCY(MD_LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .FD_OpCode    (FD_OpCode),
        .FD_Funct     (FD_Funct),
        .FD_Rs        (FD_Rs),
        .FD_Rt        (FD_Rt),
        .FD_RegWrAddr (FD_RegWrAddr),
        .FD_RegWrite  (FD_RegWrite),
        .FD_MemRead   (FD_MemRead),
        .FD_UsesRt    (FD_UsesRt),
        .EM_RegWrAddr (EM_RegWrAddr),
        .EM_RegWrite  (EM_RegWrite),
        .EM_MemRead   (EM_MemRead),
        .FD_Flush     (FD_Flush),
        .FD_Stall     (FD_Stall),
        .DE_Rs        (DE_Rs),
        .DE_Rt        (DE_Rt),
        .DE_RegWrAddr (DE_RegWrAddr),
        .DE_RegWrite  (DE_RegWrite),
        .DE_MemRead   (DE_MemRead),
        .MD_Busy      (MD_Busy)
`ifdef HAZ_PERF_EN
        ,
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

`ifndef HAZ_PERF_EN
    assign Stall_Cnt = '0;
`endif

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic       we;
        logic       mr;
        logic       ut;
    } instr_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
        logic       we;
        logic       mr;
    } stage_t;

    typedef struct {
        instr_t i;
        bit     fl;
        bit     rst;
    } step_t;

    typedef struct {
        logic stall;
        logic busy;
    } comb_exp_t;

    typedef struct {
        stage_t      de;
        logic [31:0] cnt;
    } reg_exp_t;

    comb_exp_t q_comb[$];
    reg_exp_t  q_reg[$];
    step_t     dir_q[$];

    int n_checks = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    bit rand_phase = 1'b0;

    // Reference pipeline state: what sits in DE and EM, the current decode
    // instruction, and the absolute cycle at which mult/div becomes free.
    stage_t      m_de;
    stage_t      m_em;
    instr_t      cur;
    bit          hold;
    int          m_cyc;
    int          m_md_free;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] wa, input logic we,
                                  input logic mr, input logic ut);
        instr_t x;
        x.op = op; x.fn = fn; x.rs = rs; x.rt = rt;
        x.wa = wa; x.we = we; x.mr = mr; x.ut = ut;
        return x;
    endfunction

    function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (src == dst);
    endfunction

    function automatic instr_t rand_instr();
        logic [4:0] rs = 5'($urandom_range(0, 3));
        logic [4:0] rt = 5'($urandom_range(0, 3));
        logic [4:0] wa = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 8))
            0: return mk(6'h00, 6'h20, rs, rt, wa, 1'b1, 1'b0, 1'b1);                    // add
            1: return mk(6'h23, 6'h00, rs, rt, wa, 1'b1, 1'b1, 1'b0);                    // lw
            2: return mk(6'($urandom_range(4, 5)), 6'h00, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1); // beq/bne
            3: return mk(6'h00, 6'($urandom_range(8, 9)), rs, rt, wa, 1'($urandom_range(0, 1)), 1'b0, 1'b0); // jr/jalr
            4: return mk(6'h00, 6'($urandom_range(24, 27)), rs, rt, 5'd0, 1'b0, 1'b0, 1'b1); // mult/div
            5: return mk(6'h00, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12, rs, rt, wa, 1'b1, 1'b0, 1'b0); // mfhi/mflo
            6: return mk(6'h08, 6'h00, rs, rt, wa, 1'b1, 1'b0, 1'b0);                    // addi
            7: return mk(6'h2B, 6'h00, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1);                  // sw
            default: return mk(6'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), rs, rt, wa,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        endcase
    endfunction

    // One decode cycle of the reference pipeline, from the hazard rules.
    task automatic model_step(input bit fl);
        bit busy, br, jr, mds, mdr, lu, b1, b2, md, stall;
        stage_t nde;
        busy = (m_cyc < m_md_free);
        br   = (cur.op == 6'h04) || (cur.op == 6'h05);
        jr   = (cur.op == 6'h00) && ((cur.fn == 6'h08) || (cur.fn == 6'h09));
        mds  = (cur.op == 6'h00) && (cur.fn >= 6'h18) && (cur.fn <= 6'h1B);
        mdr  = (cur.op == 6'h00) && ((cur.fn == 6'h10) || (cur.fn == 6'h12));
        lu   = m_de.mr && m_de.we && (hit(cur.rs, m_de.wa) || (cur.ut && hit(cur.rt, m_de.wa)));
        b1   = (br || jr) && m_de.we && (hit(cur.rs, m_de.wa) || (br && hit(cur.rt, m_de.wa)));
        b2   = (br || jr) && m_em.mr && m_em.we && (hit(cur.rs, m_em.wa) || (br && hit(cur.rt, m_em.wa)));
        md   = (mds || mdr) && busy;
        stall = (lu || b1 || b2 || md) && !fl;
        q_comb.push_back('{stall, busy});
        if (stall) m_cnt = m_cnt + 32'd1;
        if (stall || fl) nde = '0;
        else begin
            nde.rs = cur.rs; nde.rt = cur.rt; nde.wa = cur.wa;
            nde.we = cur.we; nde.mr = cur.mr;
        end
        if (!stall && !fl && mds) m_md_free = m_cyc + 1 + MD_LAT;
        m_em = m_de;
        m_de = nde;
        m_cyc++;
        hold = stall;
        q_reg.push_back('{nde, m_cnt});
    endtask

    task automatic drive_zero();
        FD_OpCode = '0; FD_Funct = '0; FD_Rs = '0; FD_Rt = '0; FD_RegWrAddr = '0;
        FD_RegWrite = 1'b0; FD_MemRead = 1'b0; FD_UsesRt = 1'b0;
        EM_RegWrAddr = '0; EM_RegWrite = 1'b0; EM_MemRead = 1'b0; FD_Flush = 1'b0;
    endtask

    // Asserted between clock edges so the asynchronous clear is observed
    // before any edge could mask it.
    task automatic apply_reset();
        reset_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("rst_de_rs", 32'(DE_Rs), 32'd0);
        check("rst_de_rt", 32'(DE_Rt), 32'd0);
        check("rst_de_wa", 32'(DE_RegWrAddr), 32'd0);
        check("rst_de_we", 32'(DE_RegWrite), 32'd0);
        check("rst_de_mr", 32'(DE_MemRead), 32'd0);
        check("rst_md_busy", 32'(MD_Busy), 32'd0);
`ifdef HAZ_PERF_EN
        check("rst_stall_cnt", Stall_Cnt, 32'd0);
`endif
        drive_zero();
        #1;
        check("rst_fd_stall", 32'(FD_Stall), 32'd0);
        q_comb.delete();
        q_reg.delete();
        m_de = '0; m_em = '0; cur = '0; hold = 1'b0;
        m_cyc = 0; m_md_free = 0; m_cnt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        q_reg.push_back('{stage_t'('0), 32'd0});
        mon_en = 1'b1;
    endtask

    task automatic run_cycle();
        step_t s;
        bit fl;
        s.rst = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (dir_q.size() > 0) s = dir_q.pop_front();
            else begin
                s.i = rand_instr();
                s.fl = ($urandom_range(0, 7) == 0);
            end
            cur = s.i;
            fl = s.fl;
        end else begin
            fl = rand_phase && ($urandom_range(0, 15) == 0);
        end
        FD_OpCode = cur.op; FD_Funct = cur.fn; FD_Rs = cur.rs; FD_Rt = cur.rt;
        FD_RegWrAddr = cur.wa; FD_RegWrite = cur.we; FD_MemRead = cur.mr; FD_UsesRt = cur.ut;
        EM_RegWrAddr = m_em.wa; EM_RegWrite = m_em.we; EM_MemRead = m_em.mr;
        FD_Flush = fl;
        model_step(fl);
        if (s.rst) apply_reset();
    endtask

    task automatic push(input instr_t i, input bit fl = 1'b0, input bit rst = 1'b0);
        step_t s;
        s.i = i; s.fl = fl; s.rst = rst;
        dir_q.push_back(s);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q_reg.size() > 0) begin
                reg_exp_t r;
                r = q_reg.pop_front();
                check("de_rs", 32'(DE_Rs), 32'(r.de.rs));
                check("de_rt", 32'(DE_Rt), 32'(r.de.rt));
                check("de_wa", 32'(DE_RegWrAddr), 32'(r.de.wa));
                check("de_we", 32'(DE_RegWrite), 32'(r.de.we));
                check("de_mr", 32'(DE_MemRead), 32'(r.de.mr));
`ifdef HAZ_PERF_EN
                check("stall_cnt", Stall_Cnt, r.cnt);
`endif
            end
            if (q_comb.size() > 0) begin
                comb_exp_t c;
                c = q_comb.pop_front();
                check("fd_stall", 32'(FD_Stall), 32'(c.stall));
                check("md_busy", 32'(MD_Busy), 32'(c.busy));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop;
        nop = mk(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        apply_reset();

        // lw/beq first so Stall_Cnt counts exactly two from reset
        push(mk(6'h23, 6'h00, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0));
        push(mk(6'h04, 6'h00, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        push(nop); push(nop);
        // load-use
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0));
        push(mk(6'h00, 6'h20, 5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1));
        push(nop); push(nop);
        // load-use via rt only when rt is a source
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0));
        push(mk(6'h08, 6'h00, 5'd1, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0));
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0));
        push(mk(6'h2B, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1));
        push(nop);
        // $0 destination never hazards
        push(mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1));
        push(mk(6'h00, 6'h22, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1));
        // branch after ALU producer on rt; jr after load
        push(mk(6'h00, 6'h20, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1));
        push(mk(6'h05, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1));
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0));
        push(mk(6'h00, 6'h08, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0));
        push(nop); push(nop);
        // mult then mflo, then back-to-back mult/div
        push(mk(6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1));
        push(mk(6'h00, 6'h12, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0));
        push(mk(6'h00, 6'h1A, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1));
        push(mk(6'h00, 6'h1B, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1));
        push(mk(6'h00, 6'h10, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0));
        push(nop);
        // flush overrides a load-use stall
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0));
        push(mk(6'h00, 6'h20, 5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1), 1'b1);
        push(nop);
        // reset pulsed during a load-use stall
        push(mk(6'h23, 6'h00, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0));
        push(mk(6'h00, 6'h20, 5'd8, 5'd3, 5'd10, 1'b1, 1'b0, 1'b1), 1'b0, 1'b1);
        push(nop);

        while (dir_q.size() > 0 || hold) run_cycle();

        rand_phase = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            run_cycle();
            if (n == 1500) begin
                @(posedge clk);
                #3;
                apply_reset();
            end
        end

        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
